// File: rtl/issue_age_select_if.sv
// Issue-queue <-> age-select scheduler bundle.
// master: issue queue / rename side (drives alloc and ready, observes grant and status).
// slave : issue_age_select (consumes alloc and ready, produces grant and status).
//   alloc_valid/alloc_idx : new instruction written into a slot this cycle
//   ready                 : per-slot operand-ready vector
//   grant_valid/idx/onehot: oldest ready occupied slot (idx=ENTRIES, onehot=0 when none)
//   occupied/count/full/empty : occupancy status
//   err_alloc             : sticky illegal-allocation flag
interface issue_age_select_if #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = 5
);
    logic               alloc_valid;
    logic [IDX_W-1:0]   alloc_idx;
    logic [ENTRIES-1:0] ready;
    logic               grant_valid;
    logic [IDX_W-1:0]   grant_idx;
    logic [ENTRIES-1:0] grant_onehot;
    logic [ENTRIES-1:0] occupied;
    logic [IDX_W-1:0]   count;
    logic               full;
    logic               empty;
    logic               err_alloc;

    modport master (
        output alloc_valid, alloc_idx, ready,
        input  grant_valid, grant_idx, grant_onehot, occupied, count, full, empty, err_alloc
    );

    modport slave (
        input  alloc_valid, alloc_idx, ready,
        output grant_valid, grant_idx, grant_onehot, occupied, count, full, empty, err_alloc
    );
endinterface

// File: rtl/issue_age_select.sv
// Oldest-first select for the out-of-order issue queue.
// An age matrix records allocation order of occupied slots; each cycle the single oldest
// occupied-and-ready slot is granted combinationally and retires on the clock edge unless
// STALL or FLUSH is asserted.
// Ports:
//   CLK   : clock, state updates on posedge
//   RESET : asynchronous active-low reset
//   FLUSH : synchronous clear of all tracking state (err_alloc retained)
//   STALL : execute cannot accept, nothing retires
//   bus   : issue_age_select_if.slave (alloc, ready, grant and status signals)
module issue_age_select #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = 5
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FLUSH,
    input  logic              STALL,
    issue_age_select_if.slave bus
);
    localparam int unsigned SEL_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [ENTRIES-1:0] occupied_q, occupied_d;
    // older_q[i][j] = 1: slot i was allocated before slot j
    logic [ENTRIES-1:0] older_q [ENTRIES];
    logic [ENTRIES-1:0] older_d [ENTRIES];
    logic               err_q, err_d;

    logic [ENTRIES-1:0] cand;
    logic [ENTRIES-1:0] win;
    logic               grant_valid;
    logic [IDX_W-1:0]   grant_idx;
    logic [SEL_W-1:0]   grant_slot;
    logic [SEL_W-1:0]   alloc_slot;
    logic               alloc_in_range;
    logic               alloc_legal;
    logic               fire;
    logic [IDX_W-1:0]   count;

    // Select: a candidate wins only if it is older than every other candidate.
    always_comb begin
        cand = occupied_q & bus.ready;
        win  = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            win[i] = cand[i];
            for (int j = 0; j < int'(ENTRIES); j++) begin
                if (j != i && cand[j] && !older_q[i][j]) begin
                    win[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        grant_valid = |win;
        grant_idx   = IDX_W'(ENTRIES);
        grant_slot  = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (win[i]) begin
                grant_idx  = IDX_W'(i);
                grant_slot = SEL_W'(i);
            end
        end
    end

    assign fire           = grant_valid & ~STALL & ~FLUSH;
    assign alloc_in_range = bus.alloc_idx < IDX_W'(ENTRIES);
    assign alloc_slot     = bus.alloc_idx[SEL_W-1:0];
    // Reusing the slot that retires this very cycle is allowed.
    assign alloc_legal    = alloc_in_range &&
                            (!occupied_q[alloc_slot] || (fire && grant_slot == alloc_slot));

    always_comb begin
        occupied_d = occupied_q;
        err_d      = err_q;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            older_d[i] = older_q[i];
        end

        if (FLUSH) begin
            occupied_d = '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                older_d[i] = '0;
            end
        end else begin
            if (fire) begin
                occupied_d[grant_slot] = 1'b0;
                older_d[grant_slot]    = '0;
                for (int i = 0; i < int'(ENTRIES); i++) begin
                    older_d[i][grant_slot] = 1'b0;
                end
            end
            if (bus.alloc_valid) begin
                if (alloc_legal) begin
                    // Everything still occupied after the retire is older than the new slot.
                    older_d[alloc_slot] = '0;
                    for (int i = 0; i < int'(ENTRIES); i++) begin
                        older_d[i][alloc_slot] = occupied_d[i];
                    end
                    occupied_d[alloc_slot] = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            occupied_q <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                older_q[i] <= '0;
            end
        end else begin
            occupied_q <= occupied_d;
            err_q      <= err_d;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                older_q[i] <= older_d[i];
            end
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            count = count + IDX_W'(occupied_q[i]);
        end
    end

    assign bus.grant_valid  = grant_valid;
    assign bus.grant_idx    = grant_idx;
    assign bus.grant_onehot = win;
    assign bus.occupied     = occupied_q;
    assign bus.count        = count;
    assign bus.full         = (count == IDX_W'(ENTRIES));
    assign bus.empty        = (count == '0);
    assign bus.err_alloc    = err_q;
endmodule

// File: tb/tb_issue_age_select.sv
// Scoreboard bench for issue_age_select. The reference model keeps the occupied slots as an
// age-ordered list (oldest first); the grant is the first listed slot whose ready bit is set.
module tb_issue_age_select;
    logic CLK = 1'b0;
    logic RESET = 1'b0;
    logic FLUSH = 1'b0;
    logic STALL = 1'b0;

    issue_age_select_if #(.ENTRIES(16), .IDX_W(5)) bus ();

    issue_age_select #(.ENTRIES(16), .IDX_W(5)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .FLUSH (FLUSH),
        .STALL (STALL),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        gv;
        logic [4:0]  gi;
        logic [15:0] goh;
        logic [15:0] occ;
        logic [4:0]  cnt;
        logic        full;
        logic        empty;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   age_q[$];
    logic model_err = 1'b0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int model_grant(input logic [15:0] rdy);
        foreach (age_q[i]) if (rdy[age_q[i]]) return age_q[i];
        return 16;
    endfunction

    function automatic bit in_list(input int idx);
        foreach (age_q[i]) if (age_q[i] == idx) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push_expected(input int g);
        exp_t e;
        e.gv    = (g != 16);
        e.gi    = 5'(g);
        e.goh   = (g == 16) ? 16'h0 : (16'h1 << g);
        e.occ   = '0;
        foreach (age_q[i]) e.occ[age_q[i]] = 1'b1;
        e.cnt   = 5'(age_q.size());
        e.full  = (age_q.size() == 16);
        e.empty = (age_q.size() == 0);
        e.err   = model_err;
        exp_q.push_back(e);
    endtask

    // One clock cycle of stimulus; the model advances after the edge.
    task automatic step(input logic av, input int idx, input logic [15:0] rdy,
                        input logic st, input logic fl);
        int g;
        @(negedge CLK);
        bus.alloc_valid = av;
        bus.alloc_idx   = 5'(idx);
        bus.ready       = rdy;
        STALL           = st;
        FLUSH           = fl;
        #1;
        g = model_grant(rdy);
        push_expected(g);
        @(posedge CLK);
        if (fl) begin
            age_q.delete();
        end else begin
            if (g != 16 && !st) begin
                foreach (age_q[i]) if (age_q[i] == g) begin
                    age_q.delete(i);
                    break;
                end
            end
            if (av) begin
                if (idx < 16 && !in_list(idx)) age_q.push_back(idx);
                else model_err = 1'b1;
            end
        end
    endtask

    // Asynchronous reset asserted between clock edges; checked before any edge arrives.
    task automatic mid_cycle_reset();
        @(negedge CLK);
        RESET = 1'b0;
        age_q.delete();
        model_err = 1'b0;
        #1;
        push_expected(16);
        #3;
        RESET = 1'b1;
    endtask

    // Monitor: compares whatever the driver has queued against the live outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("grant_valid", 32'(bus.grant_valid), 32'(e.gv));
                chk("grant_idx", 32'(bus.grant_idx), 32'(e.gi));
                chk("grant_onehot", 32'(bus.grant_onehot), 32'(e.goh));
                chk("occupied", 32'(bus.occupied), 32'(e.occ));
                chk("count", 32'(bus.count), 32'(e.cnt));
                chk("full", 32'(bus.full), 32'(e.full));
                chk("empty", 32'(bus.empty), 32'(e.empty));
                chk("err_alloc", 32'(bus.err_alloc), 32'(e.err));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] rdy;
        logic        st, fl, av;
        int          idx, g;

        bus.alloc_valid = 1'b0;
        bus.alloc_idx   = '0;
        bus.ready       = '0;
        mid_cycle_reset();

        // Three allocations, then drain oldest-first.
        step(1, 5, 16'h0000, 0, 0);
        step(1, 2, 16'h0000, 0, 0);
        step(1, 9, 16'h0000, 0, 0);
        step(0, 0, 16'h0000, 0, 0);
        repeat (3) step(0, 0, 16'h0224, 0, 0);
        step(0, 0, 16'h0000, 0, 0);

        // Younger ready slot wins when the older is not ready.
        step(1, 3, 16'h0000, 0, 0);
        step(1, 1, 16'h0000, 0, 0);
        step(0, 0, 16'h0002, 0, 0);
        step(0, 0, 16'h0008, 0, 0);
        step(0, 0, 16'h0000, 0, 0);

        // Fill 15..0 under stall, hold, then drain.
        for (int s = 15; s >= 0; s--) step(1, s, 16'hFFFF, 1, 0);
        repeat (3) step(0, 0, 16'hFFFF, 1, 0);
        repeat (17) step(0, 0, 16'hFFFF, 0, 0);

        // Full queue, retire and reallocate slot 7 in the same cycle.
        for (int s = 0; s < 16; s++) step(1, s, 16'h0000, 0, 0);
        step(1, 7, 16'h0080, 0, 0);
        repeat (17) step(0, 0, 16'hFFFF, 0, 0);

        // Randomized legal traffic.
        for (int n = 0; n < 500; n++) begin
            rdy = 16'($urandom);
            st  = ($urandom_range(0, 7) == 0);
            fl  = ($urandom_range(0, 40) == 0);
            av  = ($urandom_range(0, 3) != 0);
            idx = $urandom_range(0, 15);
            g   = model_grant(rdy);
            if (in_list(idx) && !(g == idx && !st)) av = 1'b0;
            step(av, idx, rdy, st, fl);
        end
        step(0, 0, 16'h0000, 0, 1);

        // Illegal allocations set the sticky error.
        step(1, 4, 16'h0000, 0, 0);
        step(1, 4, 16'hFFFF, 1, 0);
        step(1, 16, 16'h0000, 0, 0);
        step(0, 0, 16'h0000, 0, 0);

        // Flush with six occupied slots and a simultaneous alloc.
        step(1, 0, 16'h0000, 0, 0);
        step(1, 1, 16'h0000, 0, 0);
        step(1, 2, 16'h0000, 0, 0);
        step(1, 3, 16'h0000, 0, 0);
        step(1, 5, 16'h0000, 0, 0);
        step(1, 8, 16'h0021, 0, 1);
        step(0, 0, 16'hFFFF, 0, 0);

        // Mid-cycle asynchronous reset.
        step(1, 6, 16'h0000, 0, 0);
        step(1, 7, 16'h0000, 0, 0);
        bus.alloc_valid = 1'b0;
        bus.ready       = 16'hFFFF;
        mid_cycle_reset();
        step(0, 0, 16'hFFFF, 0, 0);

        @(negedge CLK);
        @(negedge CLK);
        #3;
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/issue_age_select.md
Name: issue_age_select

Overview:
- Oldest-first select scheduler for the 16-entry out-of-order issue queue.
- Tracks allocation order of occupied slots in an age matrix, ANDs it with the queue's per-slot ready vector, and picks the single oldest ready slot to send to execute each cycle.
- Replaces the fixed-priority position arbiter on the issue side: slot index no longer implies age, so this block guarantees forward progress and in-order preference among ready instructions.

Parameters:
- ENTRIES, 16, number of issue-queue slots.
- IDX_W, 5, width of slot index ports; value ENTRIES encodes "none".

Ports:
- CLK  in  1  clock, all state updates on posedge.
- RESET  in  1  asynchronous active-low reset.
- FLUSH  in  1  synchronous clear of all tracking state (branch mispredict).
- STALL  in  1  execute cannot accept; no slot retires this cycle.
- alloc_valid  in  1  rename is writing a new instruction into a slot this cycle.
- alloc_idx  in  IDX_W  slot being written; only values 0..ENTRIES-1 are legal.
- ready  in  ENTRIES  per-slot operand-ready vector from the issue queue (all source and mult ready bits ANDed).
- grant_valid  out  1  a ready occupied slot exists.
- grant_idx  out  IDX_W  oldest ready slot; ENTRIES when grant_valid=0.
- grant_onehot  out  ENTRIES  one-hot of grant_idx; zero when none.
- occupied  out  ENTRIES  slots currently tracked.
- count  out  IDX_W  popcount of occupied.
- full  out  1  count==ENTRIES.
- empty  out  1  count==0.
- err_alloc  out  1  sticky flag: alloc to an occupied, non-retiring slot or an out-of-range index.

Behaviour:
- State: occupied[ENTRIES]; age matrix older[i][j] (1 = slot i allocated before slot j; diagonal ignored); err_alloc.
- Reset (RESET low, asynchronous): occupied=0, older=0, err_alloc=0.
  - Outputs settle to grant_valid=0, grant_idx=ENTRIES, grant_onehot=0, count=0, empty=1, full=0.
- Select is combinational from the current state and ready, with zero-cycle latency:
  - cand[i] = occupied[i] & ready[i].
  - Slot i wins iff cand[i] and, for every j≠i with cand[j], older[i][j]=1.
  - At most one winner. ready on unoccupied slots is ignored.
- Retire: fire = grant_valid & !STALL & !FLUSH. On posedge, occupied[grant_idx] is cleared and its row and column in older are cleared.
- Allocate (alloc_valid & !FLUSH), on posedge for slot k=alloc_idx:
  - occupied[k] is set.
  - older[k][*]=0.
  - older[j][k]=1 for every j occupied after this cycle's retire.
  - The new slot is the youngest.
- Alloc and retire on the same slot in one cycle is legal: the retire applies first, the alloc second, and the slot ends occupied as youngest.
- Alloc and retire on different slots in one cycle: both apply; the retired slot takes no age relation to the new slot.
- Illegal alloc: alloc_idx out of range, or slot occupied and not retiring this cycle.
  - The alloc is dropped, state is unchanged, err_alloc is set.
  - err_alloc clears only on RESET.
- FLUSH on posedge: occupied=0 and older=0. FLUSH overrides alloc and retire in the same cycle. err_alloc is retained.
- STALL: grant outputs stay valid and may change as ready changes; nothing retires.
- Full: rename must not alloc; an attempt sets err_alloc unless it targets the retiring slot.
- count, full and empty are derived combinationally from occupied.

Test Plan:
- Reset, then alloc slots 5, 2, 9 in consecutive cycles with ready=0 → count=3, grant_valid=0, grant_idx=16. Then ready=16'h0224 → grant_idx=5; next cycle grant_idx=2; next cycle grant_idx=9; then empty=1.
- Slots 3 (older) and 1 (younger) occupied, ready only on 1 → grant_idx=1. Assert ready[3] the same cycle slot 1 retires → next cycle grant_idx=3.
- Fill all 16 slots in order 15..0 with ready=FFFF and STALL=1 for 3 cycles → full=1, grant_idx=15 held, count=16. Drop STALL → grants 15,14,...,0 on successive cycles.
- Full queue, grant on slot 7, alloc_idx=7 same cycle → no err_alloc, count stays 16, slot 7 is youngest (granted last when all ready).
- Alloc to occupied slot 4 while STALL=1 → err_alloc=1, count unchanged. Alloc_idx=16 → err_alloc stays 1.
- FLUSH with 6 slots occupied plus a simultaneous alloc → next cycle count=0, grant_valid=0. Assert RESET low mid-cycle → outputs reset immediately without a clock edge.
